// File: rtl/data_mem_sub.sv
// ----------------------------------------------------------------------------
// data_mem_sub
// Synchronous data memory for the MIPS datapath. Handles byte, halfword and
// word loads and stores in big-endian byte order. Loads are sign- or
// zero-extended. A misaligned access or an illegal size is flagged as an error
// and does not touch the array. Each access is one valid/ready request,
// followed by a response that is held until the consumer takes it. The load
// latency RD_LAT (1..4) is set by a parameter.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   req_valid   in   request present
//   req_ready   out  block can accept a request (IDLE only)
//   req_write   in   1 = store, 0 = load
//   req_size    in   00 byte, 01 half, 10 word, 11 illegal
//   req_signed  in   sign-extend byte/half loads
//   req_addr    in   byte address (ADDR_W bits)
//   req_wdata   in   right-justified store data
//   rsp_valid   out  response present
//   rsp_ready   in   consumer takes response
//   rsp_data    out  extended load data; 0 for stores and errors
//   rsp_err     out  misaligned access or illegal size
// ----------------------------------------------------------------------------
module data_mem_sub #(
   parameter int ADDR_W = 8,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_data,
   output logic              rsp_err
);

   localparam int DEPTH = 2 ** (ADDR_W - 2);
   localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t            state_q;
   logic [1:0]        cnt_q;
   logic [31:0]       mem_q [DEPTH];
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        size_q;
   logic              signed_q;
   logic              req_ready_q;
   logic              rsp_valid_q;
   logic              rsp_err_q;
   logic [31:0]       rsp_data_q;
   logic              req_err;

   assign req_err = (req_size == 2'b11)
                 || (req_size == 2'b01 && req_addr[0])
                 || (req_size == 2'b10 && req_addr[1:0] != 2'b00);

   // Select the addressed lane of a word (offset 0 = bits [31:24]) and extend.
   function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [1:0] off,
                                            input logic [1:0] size, input logic sgn);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (off)
         2'b00:   b = w[31:24];
         2'b01:   b = w[23:16];
         2'b10:   b = w[15:8];
         default: b = w[7:0];
      endcase
      h = off[1] ? w[15:0] : w[31:16];
      case (size)
         2'b00:   r = {{24{sgn & b[7]}}, b};
         2'b01:   r = {{16{sgn & h[15]}}, h};
         default: r = w;
      endcase
      return r;
   endfunction

   // Merge right-justified store data into the addressed lanes only.
   function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] wd,
                                               input logic [1:0] off, input logic [1:0] size);
      logic [31:0] r;
      r = w;
      case (size)
         2'b00: begin
            case (off)
               2'b00:   r[31:24] = wd[7:0];
               2'b01:   r[23:16] = wd[7:0];
               2'b10:   r[15:8]  = wd[7:0];
               default: r[7:0]   = wd[7:0];
            endcase
         end
         2'b01: begin
            if (off[1]) r[15:0] = wd[15:0];
            else        r[31:16] = wd[15:0];
         end
         default: r = wd;
      endcase
      return r;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= 2'd0;
         addr_q      <= '0;
         size_q      <= 2'b00;
         signed_q    <= 1'b0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_data_q  <= 32'd0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  addr_q      <= req_addr;
                  size_q      <= req_size;
                  signed_q    <= req_signed;
                  req_ready_q <= 1'b0;
                  if (req_err) begin
                     state_q     <= RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     rsp_data_q  <= 32'd0;
                  end else if (req_write) begin
                     // Store commits here so the next load already sees it.
                     mem_q[req_addr[ADDR_W-1:2]] <=
                        store_merge(mem_q[req_addr[ADDR_W-1:2]], req_wdata, req_addr[1:0], req_size);
                     state_q     <= RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b0;
                     rsp_data_q  <= 32'd0;
                  end else if (RD_LAT == 1) begin
                     state_q     <= RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b0;
                     rsp_data_q  <= load_fmt(mem_q[req_addr[ADDR_W-1:2]], req_addr[1:0],
                                             req_size, req_signed);
                  end else begin
                     state_q <= WAIT;
                     cnt_q   <= CNT_INIT;
                  end
               end
            end
            WAIT: begin
               if (cnt_q == 2'd1) begin
                  // Array cannot change while waiting: only one access is in flight.
                  state_q     <= RESP;
                  cnt_q       <= 2'd0;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b0;
                  rsp_data_q  <= load_fmt(mem_q[addr_q[ADDR_W-1:2]], addr_q[1:0], size_q, signed_q);
               end else begin
                  cnt_q <= cnt_q - 2'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state_q     <= IDLE;
                  req_ready_q <= 1'b1;
                  rsp_valid_q <= 1'b0;
                  rsp_err_q   <= 1'b0;
                  rsp_data_q  <= 32'd0;
               end
            end
            default: begin
               state_q     <= IDLE;
               req_ready_q <= 1'b1;
               rsp_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_sub.sv
// ----------------------------------------------------------------------------
// tb_data_mem_sub
// Drives three instances (RD_LAT = 1, 3, 4) with shared stimulus and checks
// each one against a byte-addressed big-endian reference memory.
// ----------------------------------------------------------------------------
module tb_data_mem_sub;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [7:0]  req_addr;
   logic [31:0] req_wdata;
   logic        rsp_ready;
   logic [2:0]  rdy;
   logic [2:0]  vld;
   logic [2:0]  errs;
   logic [31:0] rdata [3];

   int checks = 0;
   int errors = 0;

   logic [7:0] mem_m [256];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      data_mem_sub #(.ADDR_W(8), .RD_LAT((g == 0) ? 1 : g + 2)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .req_valid (req_valid),
         .req_ready (rdy[g]),
         .req_write (req_write),
         .req_size  (req_size),
         .req_signed(req_signed),
         .req_addr  (req_addr),
         .req_wdata (req_wdata),
         .rsp_valid (vld[g]),
         .rsp_ready (rsp_ready),
         .rsp_data  (rdata[g]),
         .rsp_err   (errs[g])
      );
   end

   function automatic int lat_of(input int d);
      return (d == 0) ? 1 : d + 2;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic model_err(input logic [1:0] sz, input logic [7:0] a);
      return (sz == 2'b11) || (sz == 2'b01 && (a % 2) != 0) || (sz == 2'b10 && (a % 4) != 0);
   endfunction

   function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg, input logic [7:0] a);
      int i;
      logic [31:0] v;
      i = int'(a);
      case (sz)
         2'b00: begin
            v = {24'd0, mem_m[i]};
            if (sg && mem_m[i][7]) v = v | 32'hFFFFFF00;
         end
         2'b01: begin
            v = {16'd0, mem_m[i], mem_m[i+1]};
            if (sg && mem_m[i][7]) v = v | 32'hFFFF0000;
         end
         default: v = {mem_m[i], mem_m[i+1], mem_m[i+2], mem_m[i+3]};
      endcase
      return v;
   endfunction

   task automatic model_store(input logic [1:0] sz, input logic [7:0] a, input logic [31:0] wd);
      int i;
      i = int'(a);
      case (sz)
         2'b00: mem_m[i] = wd[7:0];
         2'b01: begin mem_m[i] = wd[15:8]; mem_m[i+1] = wd[7:0]; end
         default: begin
            mem_m[i] = wd[31:24]; mem_m[i+1] = wd[23:16];
            mem_m[i+2] = wd[15:8]; mem_m[i+3] = wd[7:0];
         end
      endcase
   endtask

   // One transaction with rsp_ready held high; checks latency, data, error,
   // one-cycle pulse width on every instance. Starts and ends 1 time unit
   // after a rising edge.
   task automatic xact(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [7:0] a, input logic [31:0] wd, output logic [31:0] got);
      logic        e;
      logic [31:0] exp_d;
      logic [2:0]  seen;
      e     = model_err(sz, a);
      exp_d = (wr || e) ? 32'd0 : model_load(sz, sg, a);
      if (wr && !e) model_store(sz, a, wd);
      got        = 32'd0;
      seen       = 3'b000;
      req_write  = wr;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = wd;
      req_valid  = 1'b1;
      rsp_ready  = 1'b1;
      @(posedge clk); #1;
      req_valid  = 1'b0;
      req_addr   = 8'(~a);
      req_wdata  = ~wd;
      for (int k = 0; k < 8; k++) begin
         for (int d = 0; d < 3; d++) begin
            if (vld[d] && !seen[d]) begin
               seen[d] = 1'b1;
               chk($sformatf("latency_dut%0d", d), k + 1, (wr || e) ? 1 : lat_of(d));
               chk($sformatf("data_dut%0d_a%0d", d, a), rdata[d], exp_d);
               chk($sformatf("err_dut%0d_a%0d", d, a), {31'd0, errs[d]}, {31'd0, e});
               if (d == 0) got = rdata[d];
            end else if (seen[d]) begin
               chk($sformatf("pulse_dut%0d", d), {31'd0, vld[d]}, 32'd0);
            end
         end
         @(posedge clk); #1;
      end
      chk("responded", {29'd0, seen}, 32'd7);
      chk("ready_after", {29'd0, rdy}, 32'd7);
   endtask

   initial begin
      logic [31:0] got;
      logic [31:0] exp_d;
      int          n;
      for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b10;
      req_signed = 1'b0; req_addr = 8'h00; req_wdata = 32'h0; rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("rst_ready%0d", d), {31'd0, rdy[d]}, 32'd1);
         chk($sformatf("rst_valid%0d", d), {31'd0, vld[d]}, 32'd0);
         chk($sformatf("rst_data%0d", d), rdata[d], 32'd0);
         chk($sformatf("rst_err%0d", d), {31'd0, errs[d]}, 32'd0);
      end
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed sequence
      xact(1'b0, 2'b10, 1'b0, 8'd8, 32'h0, got);
      chk("lw8_zero", got, 32'h0000_0000);
      xact(1'b1, 2'b10, 1'b0, 8'd4, 32'h1A2B3C4D, got);
      xact(1'b0, 2'b10, 1'b0, 8'd4, 32'h0, got);
      chk("lw4", got, 32'h1A2B3C4D);
      xact(1'b1, 2'b00, 1'b0, 8'd6, 32'h0000_00F0, got);
      xact(1'b0, 2'b10, 1'b0, 8'd4, 32'h0, got);
      chk("lw4_after_sb", got, 32'h1A2BF04D);
      xact(1'b0, 2'b00, 1'b1, 8'd6, 32'h0, got);
      chk("lb6", got, 32'hFFFFFFF0);
      xact(1'b0, 2'b00, 1'b0, 8'd6, 32'h0, got);
      chk("lbu6", got, 32'h000000F0);
      xact(1'b0, 2'b01, 1'b1, 8'd4, 32'h0, got);
      chk("lh4", got, 32'h00001A2B);
      xact(1'b0, 2'b01, 1'b1, 8'd6, 32'h0, got);
      chk("lh6", got, 32'hFFFFF04D);
      xact(1'b0, 2'b10, 1'b0, 8'd5, 32'h0, got);
      xact(1'b1, 2'b01, 1'b0, 8'd7, 32'hFFFF_FFFF, got);
      xact(1'b0, 2'b10, 1'b0, 8'd4, 32'h0, got);
      chk("lw4_after_bad_sh", got, 32'h1A2BF04D);
      xact(1'b0, 2'b11, 1'b0, 8'd0, 32'h0, got);
      xact(1'b1, 2'b11, 1'b0, 8'd12, 32'h1234_5678, got);

      // Randomized traffic
      for (int t = 0; t < 200; t++) begin
         logic [7:0] a;
         a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 31));
         xact(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              a, $urandom, got);
      end

      // Backpressure, observed on the RD_LAT=3 instance
      exp_d = model_load(2'b10, 1'b0, 8'd4);
      rsp_ready = 1'b0;
      req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 8'd4;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      while (!vld[1] && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      chk("bp_reached_valid", {31'd0, vld[1]}, 32'd1);
      req_write = 1'b1; req_wdata = 32'hDEADBEEF; req_addr = 8'd4; req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", {31'd0, vld[1]}, 32'd1);
         chk("bp_data", rdata[1], exp_d);
         chk("bp_ready", {31'd0, rdy[1]}, 32'd0);
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_released_valid", {29'd0, vld}, 32'd0);
      chk("bp_released_ready", {29'd0, rdy}, 32'd7);
      xact(1'b0, 2'b10, 1'b0, 8'd4, 32'h0, got);
      chk("bp_store_ignored", got, exp_d);

      // Reset while the RD_LAT=4 instance is waiting
      rsp_ready = 1'b0;
      req_write = 1'b0; req_size = 2'b10; req_addr = 8'd4; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_valid", {29'd0, vld}, 32'd0);
      chk("midrst_ready", {29'd0, rdy}, 32'd7);
      chk("midrst_data2", rdata[2], 32'd0);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
      rsp_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         chk("midrst_no_rsp", {29'd0, vld}, 32'd0);
      end
      xact(1'b0, 2'b10, 1'b0, 8'd4, 32'h0, got);
      chk("midrst_lw4", got, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog");
   end

endmodule
